vball_gfx_arb: RTL

VBALL_GFX_ARB -- requirements
Module: vball_gfx_arb

---
 rtl/vball_gfx_arb_pkg.sv | 17 +
 rtl/vball_gfx_arb_pick.sv | 39 +++
 rtl/vball_gfx_arb.sv | 136 +++++++++++++
 3 files changed

// File: rtl/vball_gfx_arb_pkg.sv
// Shared state encoding, requester ids and defaults for the gfx ROM arbiter.
package vball_gfx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  localparam logic ID_BG  = 1'b0;
  localparam logic ID_SPR = 1'b1;

  localparam int TIMEOUT_DEFAULT = 15;
  localparam int TIMER_W         = 8;

endpackage

// File: rtl/vball_gfx_arb_pick.sv
// Grant selection between the bg and sprite requesters: fixed bg priority,
// or round-robin on a last-winner pointer when VBALL_GFX_ARB_RR_EN is defined.
module vball_gfx_arb_pick
  import vball_gfx_arb_pkg::*;
(
`ifdef VBALL_GFX_ARB_RR_EN
  input  logic clk_sys,
  input  logic rst_n,
  input  logic take_i,
`endif
  input  logic bg_req_i,
  input  logic spr_req_i,
  output logic valid_o,
  output logic id_o
);

  assign valid_o = bg_req_i | spr_req_i;

`ifdef VBALL_GFX_ARB_RR_EN
  logic last_q, last_d;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) last_q <= ID_BG;
    else        last_q <= last_d;
  end

  // On contention the requester that did not win last time is chosen.
  always_comb begin
    id_o   = ID_BG;
    last_d = last_q;
    if (bg_req_i && spr_req_i) id_o = ~last_q;
    else if (spr_req_i)        id_o = ID_SPR;
    if (take_i && valid_o) last_d = id_o;
  end
`else
  assign id_o = bg_req_i ? ID_BG : ID_SPR;
`endif

endmodule

// File: rtl/vball_gfx_arb.sv
// Two-requester arbiter (bg and sprite layers) for the shared gfx ROM.
// Define VBALL_GFX_ARB_RR_EN for round-robin instead of fixed bg priority.
module vball_gfx_arb
  import vball_gfx_arb_pkg::*;
#(
  parameter int ADDR_W  = 19,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk_sys,
  input  logic              rst_n,
  input  logic              bg_req,
  input  logic [ADDR_W-1:0] bg_addr,
  output logic [7:0]        bg_data,
  output logic              bg_ack,
  input  logic              spr_req,
  input  logic [ADDR_W-1:0] spr_addr,
  output logic [7:0]        spr_data,
  output logic              spr_ack,
  output logic              rom_rd,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  input  logic              rom_valid,
  output logic              busy,
  output logic              timeout_err
);

  localparam logic [TIMER_W-1:0] TIMEOUT_T = TIMER_W'(TIMEOUT);

  state_e              state_q, state_d;
  logic                id_q, id_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic                rom_rd_q, rom_rd_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [7:0]          bg_data_q, bg_data_d, spr_data_q, spr_data_d;
  logic                bg_ack_q, bg_ack_d, spr_ack_q, spr_ack_d;
  logic                err_q, err_d;
  logic [7:0]          rsp_data;
  logic                grant_valid, grant_id;

  vball_gfx_arb_pick u_pick (
`ifdef VBALL_GFX_ARB_RR_EN
    .clk_sys   (clk_sys),
    .rst_n     (rst_n),
    .take_i    (state_q == IDLE),
`endif
    .bg_req_i  (bg_req),
    .spr_req_i (spr_req),
    .valid_o   (grant_valid),
    .id_o      (grant_id)
  );

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      id_q       <= ID_BG;
      rom_addr_q <= '0;
      rom_rd_q   <= 1'b0;
      timer_q    <= '0;
      bg_data_q  <= '0;
      spr_data_q <= '0;
      bg_ack_q   <= 1'b0;
      spr_ack_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      rom_addr_q <= rom_addr_d;
      rom_rd_q   <= rom_rd_d;
      timer_q    <= timer_d;
      bg_data_q  <= bg_data_d;
      spr_data_q <= spr_data_d;
      bg_ack_q   <= bg_ack_d;
      spr_ack_q  <= spr_ack_d;
      err_q      <= err_d;
    end
  end

  // rom_rd and the acks are registered, so they are set on the transition
  // into ISSUE / RESP and are high for exactly that state's cycle.
  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    rom_addr_d = rom_addr_q;
    rom_rd_d   = 1'b0;
    timer_d    = timer_q;
    bg_data_d  = bg_data_q;
    spr_data_d = spr_data_q;
    bg_ack_d   = 1'b0;
    spr_ack_d  = 1'b0;
    err_d      = err_q;
    rsp_data   = rom_valid ? rom_data : 8'hFF;

    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          id_d       = grant_id;
          rom_addr_d = (grant_id == ID_SPR) ? spr_addr : bg_addr;
          rom_rd_d   = 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A valid in the final timer cycle still wins over the abort.
        if (rom_valid || (timer_q == TIMEOUT_T)) begin
          if (id_q == ID_SPR) begin
            spr_data_d = rsp_data;
            spr_ack_d  = 1'b1;
          end else begin
            bg_data_d = rsp_data;
            bg_ack_d  = 1'b1;
          end
          err_d   = err_q | ~rom_valid;
          state_d = RESP;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bg_data     = bg_data_q;
  assign bg_ack      = bg_ack_q;
  assign spr_data    = spr_data_q;
  assign spr_ack     = spr_ack_q;
  assign rom_rd      = rom_rd_q;
  assign rom_addr    = rom_addr_q;
  assign busy        = (state_q != IDLE);
  assign timeout_err = err_q;

endmodule
